// File: rtl/noc_input_buffer_bank.sv
// Bank of NUM_CH independent first-word-fall-through input FIFOs with occupancy, almost-full and sticky error flags.
// Latency: a written flit appears on rdata/rvalid one cycle after its write edge; status outputs decode registered count.
// Backpressure: wfull/wafull advertise occupancy upstream; a write to a full channel without a same-cycle pop is dropped and flagged.

// Single channel FIFO: pointer/counter storage with sticky error tracking.
module noc_ibb_fifo #(
   parameter int DEPTH    = 8,
   parameter int DATASIZE = 40,
   parameter int AFULL_TH = 6,
   parameter int CNTW     = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                winc,
   input  logic                rinc,
   input  logic                err_clr,
   output logic [DATASIZE-1:0] rdata,
   output logic                rvalid,
   output logic                wfull,
   output logic                wafull,
   output logic [CNTW-1:0]     count,
   output logic                ovf_err,
   output logic                udf_err
);
   localparam int PW = $clog2(DEPTH);

   logic [DATASIZE-1:0] mem [DEPTH];
   logic [PW-1:0]       wptr;
   logic [PW-1:0]       rptr;
   logic [CNTW-1:0]     cnt;
   logic                empty;
   logic                full;
   logic                ra;
   logic                wa;

   // Status is decoded from the registered count only, so it never depends on this cycle's requests.
   always_comb begin
      empty  = (cnt == '0);
      full   = (cnt == CNTW'(DEPTH));
      // A pop frees a slot in the same cycle, so a full FIFO may still accept a write alongside it.
      ra     = rinc & ~empty;
      wa     = winc & (~full | ra);
      rvalid = ~empty;
      wfull  = full;
      wafull = (cnt >= CNTW'(AFULL_TH));
      count  = cnt;
      rdata  = mem[rptr];
   end

   // Storage is not reset; writes are simply blocked during a reset cycle.
   always_ff @(posedge clk) begin
      if (!rst && wa) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers, occupancy and sticky errors; a new error wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         if (wa) wptr <= wptr + PW'(1);
         if (ra) rptr <= rptr + PW'(1);
         if (wa && !ra)      cnt <= cnt + CNTW'(1);
         else if (ra && !wa) cnt <= cnt - CNTW'(1);
         if (winc && full && !ra) ovf_err <= 1'b1;
         else if (err_clr)        ovf_err <= 1'b0;
         if (rinc && empty)       udf_err <= 1'b1;
         else if (err_clr)        udf_err <= 1'b0;
      end
   end
endmodule

// Replicates the channel FIFO across the packed per-channel port vectors.
module noc_input_buffer_bank #(
   parameter int NUM_CH   = 5,
   parameter int DEPTH    = 8,
   parameter int DATASIZE = 40,
   parameter int AFULL_TH = 6,
   parameter int CNTW     = $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATASIZE-1:0]   wdata,
   input  logic [NUM_CH-1:0]            winc,
   output logic [NUM_CH-1:0]            wfull,
   output logic [NUM_CH-1:0]            wafull,
   output logic [NUM_CH*DATASIZE-1:0]   rdata,
   output logic [NUM_CH-1:0]            rvalid,
   input  logic [NUM_CH-1:0]            rinc,
   output logic [NUM_CH*CNTW-1:0]       count,
   input  logic                         err_clr,
   output logic [NUM_CH-1:0]            ovf_err,
   output logic [NUM_CH-1:0]            udf_err
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      noc_ibb_fifo #(
         .DEPTH    (DEPTH),
         .DATASIZE (DATASIZE),
         .AFULL_TH (AFULL_TH),
         .CNTW     (CNTW)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wdata   (wdata[i*DATASIZE +: DATASIZE]),
         .winc    (winc[i]),
         .rinc    (rinc[i]),
         .err_clr (err_clr),
         .rdata   (rdata[i*DATASIZE +: DATASIZE]),
         .rvalid  (rvalid[i]),
         .wfull   (wfull[i]),
         .wafull  (wafull[i]),
         .count   (count[i*CNTW +: CNTW]),
         .ovf_err (ovf_err[i]),
         .udf_err (udf_err[i])
      );
   end
endmodule
